// File: rtl/dw_sar_cmp_search.sv
// Successive-approximation search: digitises a target seen only through an external A-vs-B comparator.
// Latency: each step is PROBE plus max(CMP_LAT,1) cycles (CMP_LAT+1 for CMP_LAT>=1); at most WIDTH steps.
// Backpressure: the result is held in DONE until res_ready; start_ready is high only in IDLE.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start_valid/ready/tc     search request handshake; tc selects a signed target
//   abort                    cancel any active search, return to IDLE
//   cmp_a, cmp_tc, cmp_probe registered probe, signedness and new-probe strobe to the comparator
//   cmp_le, cmp_eq           comparator flags, sampled only in SAMPLE
//   res_valid/ready          result handshake
//   res_value/early/steps    found target, EQ-hit flag, number of probes issued
module dw_sar_cmp_search #(
  parameter int  WIDTH   = 8,
  parameter int  CMP_LAT = 1,
  localparam int SW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             start_tc,
  input  logic             abort,
  output logic [WIDTH-1:0] cmp_a,
  output logic             cmp_tc,
  output logic             cmp_probe,
  input  logic             cmp_le,
  input  logic             cmp_eq,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_value,
  output logic             res_early,
  output logic [SW-1:0]    res_steps
);

  localparam int KW = $clog2(WIDTH);
  // WAIT covers the latency cycles between PROBE and SAMPLE; unused when CMP_LAT <= 1.
  localparam int WAIT_LAST = (CMP_LAT >= 2) ? CMP_LAT - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] u_smp;
  logic [WIDTH-1:0] tc_mask;
  logic [KW-1:0]    k;
  logic [2:0]       wcnt;
  logic             kill;

  // Flipping the MSB maps signed targets onto an unsigned, monotonic search space.
  assign tc_mask = {cmp_tc, {(WIDTH-1){1'b0}}};
  assign bit_k   = {{(WIDTH-1){1'b0}}, 1'b1} << k;
  assign trial   = u | bit_k;
  // EQ implies the trial bit belongs in the answer even if LE is (faultily) low.
  assign u_smp   = (cmp_eq || cmp_le) ? trial : u;
  assign kill    = abort && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_ready = (state == S_IDLE);
    res_valid   = (state == S_DONE);
    case (state)
      S_IDLE:   if (start_valid) state_nxt = S_PROBE;
      S_PROBE:  state_nxt = (CMP_LAT <= 1) ? S_SAMPLE : S_WAIT;
      S_WAIT:   if (wcnt == 3'(WAIT_LAST)) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (cmp_eq || (k == '0)) ? S_DONE : S_PROBE;
      S_DONE:   if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  // cmp_a is loaded on the edge that enters PROBE so the comparator sees the
  // trial for the whole step, and SAMPLE lands exactly CMP_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      u         <= '0;
      k         <= '0;
      wcnt      <= '0;
      cmp_a     <= '0;
      cmp_tc    <= 1'b0;
      cmp_probe <= 1'b0;
      res_value <= '0;
      res_early <= 1'b0;
      res_steps <= '0;
    end else begin
      cmp_probe <= 1'b0;
      if (kill) begin
        cmp_a <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_valid) begin
              cmp_tc    <= start_tc;
              u         <= '0;
              k         <= KW'(WIDTH - 1);
              res_steps <= '0;
              res_early <= 1'b0;
              cmp_a     <= {~start_tc, {(WIDTH-1){1'b0}}};
              cmp_probe <= 1'b1;
            end
          end
          S_PROBE: begin
            res_steps <= res_steps + SW'(1);
            wcnt      <= '0;
          end
          S_WAIT: begin
            wcnt <= wcnt + 3'd1;
          end
          S_SAMPLE: begin
            u <= u_smp;
            if (cmp_eq || (k == '0)) begin
              res_value <= u_smp ^ tc_mask;
              res_early <= cmp_eq;
            end else begin
              k         <= k - KW'(1);
              cmp_a     <= (u_smp | (bit_k >> 1)) ^ tc_mask;
              cmp_probe <= 1'b1;
            end
          end
          S_DONE: begin
            if (res_ready) cmp_a <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dw_sar_cmp_search.sv
// Bench for dw_sar_cmp_search: three instances (CMP_LAT = 1, 0, 3), each with a behavioural comparator.
// Directed cases run on instance 0; both signedness sweeps run on instances 1 and 2.
// Expected results come from a bit-position model and flow through a scoreboard queue.
module tb_dw_sar_cmp_search;
  localparam int W  = 8;
  localparam int N  = 3;
  localparam int SW = $clog2(W + 1);

  typedef struct packed {
    logic [W-1:0]  value;
    logic          early;
    logic [SW-1:0] steps;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_valid [N];
  logic          start_ready [N];
  logic          start_tc    [N];
  logic          abort_req   [N];
  logic [W-1:0]  cmp_a       [N];
  logic          cmp_tc      [N];
  logic          cmp_probe   [N];
  logic          cmp_le      [N];
  logic          cmp_eq      [N];
  logic          res_valid   [N];
  logic          res_ready   [N];
  logic [W-1:0]  res_value   [N];
  logic          res_early   [N];
  logic [SW-1:0] res_steps   [N];
  logic [W-1:0]  tgt         [N];

  int   lat_of [N] = '{1, 0, 3};
  exp_t sb[$];
  logic [W-1:0] probe_log[$];
  int   n_pass  = 0;
  int   n_total = 0;

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int HI  = (LAT == 0) ? 0 : LAT - 1;
    logic [W-1:0] hist [8];
    logic [W-1:0] a_seen;

    dw_sar_cmp_search #(.WIDTH(W), .CMP_LAT(LAT)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid[g]),
      .start_ready (start_ready[g]),
      .start_tc    (start_tc[g]),
      .abort       (abort_req[g]),
      .cmp_a       (cmp_a[g]),
      .cmp_tc      (cmp_tc[g]),
      .cmp_probe   (cmp_probe[g]),
      .cmp_le      (cmp_le[g]),
      .cmp_eq      (cmp_eq[g]),
      .res_valid   (res_valid[g]),
      .res_ready   (res_ready[g]),
      .res_value   (res_value[g]),
      .res_early   (res_early[g]),
      .res_steps   (res_steps[g])
    );

    // Comparator flags reflect cmp_a as it was LAT cycles ago.
    always @(posedge clk) begin
      hist[0] <= cmp_a[g];
      for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end
    assign a_seen    = (LAT == 0) ? cmp_a[g] : hist[HI];
    assign cmp_le[g] = cmp_tc[g] ? ($signed(a_seen) <= $signed(tgt[g])) : (a_seen <= tgt[g]);
    assign cmp_eq[g] = (a_seen == tgt[g]);
  end

  always @(posedge clk) if (!rst && cmp_probe[0]) probe_log.push_back(cmp_a[0]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // The search hits EQ once every bit below the lowest set bit of the offset-mapped target is zero.
  function automatic exp_t model(input logic tc, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] u;
    int tz;
    u = b ^ {tc, {(W-1){1'b0}}};
    e.value = b;
    e.early = (u != '0);
    tz = 0;
    if (u != '0) while (!u[tz]) tz++;
    e.steps = (u == '0) ? SW'(W) : SW'(W - tz);
    return e;
  endfunction

  task automatic start_search(input int i, input logic tc, input logic [W-1:0] b);
    tgt[i]      = b;
    start_tc[i] = tc;
    sb.push_back(model(tc, b));
    check("start_ready_idle", start_ready[i], 1);
    start_valid[i] = 1'b1;
    @(posedge clk); #1;
    start_valid[i] = 1'b0;
    start_tc[i]    = ~tc;
  endtask

  task automatic wait_result(input int i, input int exp_lat, input int hold);
    exp_t e;
    int   cyc;
    logic [W-1:0] v0;
    cyc = 0;
    while (!res_valid[i] && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    if (!res_valid[i]) begin
      check("res_timeout", 0, 1);
      return;
    end
    check("res_value", res_value[i], e.value);
    check("res_early", res_early[i], e.early);
    check("res_steps", res_steps[i], e.steps);
    check("latency", cyc, exp_lat);
    v0 = res_value[i];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", res_valid[i], 1);
      check("hold_value", res_value[i], v0);
      check("hold_start_ready", start_ready[i], 0);
    end
    res_ready[i] = 1'b1;
    @(posedge clk); #1;
    res_ready[i] = 1'b0;
    check("valid_drop", res_valid[i], 0);
    check("start_ready_back", start_ready[i], 1);
  endtask

  task automatic check_probes(input int base, input logic [W-1:0] exp_p [], input string tag);
    check({tag, "_count"}, probe_log.size() - base, exp_p.size());
    for (int j = 0; j < exp_p.size(); j++)
      if (base + j < probe_log.size()) check(tag, probe_log[base + j], exp_p[j]);
  endtask

  task automatic interrupted_search(input logic use_rst);
    int base;
    int seen;
    exp_t dropped;
    base = probe_log.size();
    start_search(0, 1'b0, 8'h5A);
    for (int c = 0; c < 100 && probe_log.size() < base + 3; c++) begin
      @(posedge clk); #1;
    end
    check("reach_step3", probe_log.size() >= base + 3, 1);
    if (use_rst) rst = 1'b1; else abort_req[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    abort_req[0] = 1'b0;
    check("cancel_idle", start_ready[0], 1);
    check("cancel_cmp_a", cmp_a[0], 0);
    check("cancel_valid", res_valid[0], 0);
    if (use_rst) begin
      check("rst_res_value", res_value[0], 0);
      check("rst_res_steps", res_steps[0], 0);
      check("rst_cmp_tc", cmp_tc[0], 0);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (res_valid[0]) seen++;
    end
    check("cancel_no_result", seen, 0);
    dropped = sb.pop_back();
    start_search(0, 1'b0, 8'h33);
    wait_result(0, 2 * int'(model(1'b0, 8'h33).steps), 0);
  endtask

  initial begin
    logic [W-1:0] p1 [] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
    logic [W-1:0] p2 [] = '{8'h00, 8'hC0, 8'hE0, 8'hF0};
    int base;
    exp_t e;
    int step_cyc;

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start_valid[i] = 1'b0;
      start_tc[i]    = 1'b0;
      abort_req[i]   = 1'b0;
      res_ready[i]   = 1'b0;
      tgt[i]         = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_cmp_a", cmp_a[0], 0);
    check("rst_cmp_tc", cmp_tc[0], 0);
    check("rst_cmp_probe", cmp_probe[0], 0);
    check("rst_res_valid", res_valid[0], 0);
    check("rst_res_value", res_value[0], 0);
    check("rst_res_early", res_early[0], 0);
    check("rst_res_steps", res_steps[0], 0);
    check("rst_start_ready", start_ready[0], 1);

    base = probe_log.size();
    start_search(0, 1'b0, 8'h5A);
    wait_result(0, 14, 0);
    check_probes(base, p1, "probe_5a");

    base = probe_log.size();
    start_search(0, 1'b1, 8'hF0);
    wait_result(0, 8, 0);
    check_probes(base, p2, "probe_f0");

    start_search(0, 1'b0, 8'h00);
    wait_result(0, 16, 0);
    start_search(0, 1'b0, 8'hFF);
    wait_result(0, 16, 0);
    start_search(0, 1'b1, 8'h80);
    wait_result(0, 16, 0);
    start_search(0, 1'b1, 8'h7F);
    wait_result(0, 16, 5);

    interrupted_search(1'b0);
    interrupted_search(1'b1);

    for (int i = 1; i < N; i++) begin
      step_cyc = ((lat_of[i] < 1) ? 1 : lat_of[i]) + 1;
      for (int tc = 0; tc < 2; tc++) begin
        for (int b = 0; b < 256; b++) begin
          e = model(tc[0], b[W-1:0]);
          start_search(i, tc[0], b[W-1:0]);
          wait_result(i, step_cyc * int'(e.steps), 0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
